// File: rtl/pixel_stream_tx.sv
// ---------------------------------------------------------------------------
// pixel_stream_tx
//
// Buffers host pixels in a DEPTH-entry FIFO and hands them one at a time to a
// downstream consumer over a SEND/ACK token handshake. The FIFO feeds a single
// output holding register that drives Out1_DATA. A two-state transmitter
// (IDLE/OFFER) moves the FIFO head into that register. Consecutive tokens go
// out back-to-back, with no idle cycle between them, while the consumer keeps
// acknowledging and stays ready.
//
// Optional feature (macro PIXEL_STREAM_TX_EOF_EN):
//   When defined, a 32-bit counter counts acknowledged tokens. Out1_EOF pulses
//   on the ACK of token FRAME_TOKENS-1, and the counter then wraps to 0.
//   When undefined, the counter does not exist and Out1_EOF is tied low.
//
// Parameters
//   DEPTH        FIFO entries (power of two, 4..64)
//   FRAME_TOKENS tokens per frame (used only with PIXEL_STREAM_TX_EOF_EN)
//
// Ports
//   CLK          rising-edge clock
//   RESET        synchronous, active-low reset
//   wr_en        host write strobe
//   wr_data[7:0] host pixel
//   wr_full      FIFO holds DEPTH entries
//   overflow     sticky: a write was dropped because the FIFO was full
//   Out1_DATA    token data (holding register)
//   Out1_SEND    token valid (transmitter in OFFER)
//   Out1_COUNT   tokens offered: 1 in OFFER, 0 in IDLE
//   Out1_ACK     consumer takes the token
//   Out1_RDY     consumer may accept a new token
//   Out1_EOF     one-cycle pulse on the ACK of the last token of a frame
// ---------------------------------------------------------------------------
module pixel_stream_tx #(
    parameter int          DEPTH        = 16,
    parameter logic [31:0] FRAME_TOKENS = 32'h40000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        wr_full,
    output logic        overflow,
    output logic [7:0]  Out1_DATA,
    output logic        Out1_SEND,
    output logic [15:0] Out1_COUNT,
    input  logic        Out1_ACK,
    input  logic        Out1_RDY,
    output logic        Out1_EOF
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 ||
        FRAME_TOKENS == 32'd0) begin : g_bad_param
        $error("pixel_stream_tx: DEPTH must be a power of two in 4..64 and FRAME_TOKENS nonzero");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [7:0]    data_q;
    logic          overflow_q;

    logic fifo_empty, fifo_full;
    logic pop, push, drop, ack_tok;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (AW+1)'(DEPTH));
    assign ack_tok    = (state_q == OFFER) && Out1_ACK;

    // A pop in the same cycle frees a slot, so a write into a full FIFO is
    // only dropped when nothing is leaving.
    assign push = wr_en && (!fifo_full || pop);
    assign drop = wr_en && fifo_full && !pop;

    // Transmitter: ACK is only looked at while offering, so an ACK in IDLE
    // has no effect.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && Out1_RDY) begin
                    pop     = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (ack_tok) begin
                    if (!fifo_empty && Out1_RDY) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            data_q     <= 8'h0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                data_q   <= mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; occupancy and pointers define validity.
    // When full, the write and read address coincide, and the pop still sees
    // the old head because both updates land on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_full    = fifo_full;
    assign overflow   = overflow_q;
    assign Out1_DATA  = data_q;
    assign Out1_SEND  = (state_q == OFFER);
    assign Out1_COUNT = {15'h0, (state_q == OFFER)};

`ifdef PIXEL_STREAM_TX_EOF_EN
    logic [31:0] tok_cnt_q;
    logic        last_tok;

    assign last_tok = (tok_cnt_q == FRAME_TOKENS - 32'd1);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tok_cnt_q <= 32'd0;
        end else if (ack_tok) begin
            tok_cnt_q <= last_tok ? 32'd0 : tok_cnt_q + 32'd1;
        end
    end

    assign Out1_EOF = ack_tok && last_tok;
`else
    assign Out1_EOF = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_stream_tx.sv
module tb_pixel_stream_tx;

    localparam int TB_FRAME = 4;
`ifdef PIXEL_STREAM_TX_EOF_EN
    localparam bit EOF_ON = 1'b1;
`else
    localparam bit EOF_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_full;
    logic        overflow;
    logic [7:0]  Out1_DATA;
    logic        Out1_SEND;
    logic [15:0] Out1_COUNT;
    logic        Out1_ACK;
    logic        Out1_RDY;
    logic        Out1_EOF;

    pixel_stream_tx #(
        .DEPTH(16),
        .FRAME_TOKENS(32'(TB_FRAME))
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_full(wr_full),
        .overflow(overflow),
        .Out1_DATA(Out1_DATA),
        .Out1_SEND(Out1_SEND),
        .Out1_COUNT(Out1_COUNT),
        .Out1_ACK(Out1_ACK),
        .Out1_RDY(Out1_RDY),
        .Out1_EOF(Out1_EOF)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] d;
        logic       eof;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   ord      = 0;
    int   eof_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected token; EOF marks every TB_FRAME-th accepted token since reset.
    task automatic sb_push(input logic [7:0] d);
        exp_t e;
        e.d   = d;
        e.eof = EOF_ON && ((ord % TB_FRAME) == TB_FRAME - 1);
        sb.push_back(e);
        ord++;
    endtask

    task automatic wait_drain(input int bound);
        bit done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            if (sb.size() == 0 && !Out1_SEND) done = 1'b1;
            else tick();
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    // Monitor: consumes one expected token per accepted handshake and checks
    // that an un-ACKed offer stays put.
    initial begin
        bit         prev_hold = 1'b0;
        logic [7:0] prev_data = 8'h0;
        exp_t       e;
        forever begin
            @(negedge CLK);
            if (RESET !== 1'b1) begin
                prev_hold = 1'b0;
            end else begin
                if (Out1_EOF === 1'b1) eof_seen++;
                if (prev_hold) begin
                    chk("hold_send", 32'(Out1_SEND), 32'd1);
                    chk("hold_data", 32'(Out1_DATA), 32'(prev_data));
                end
                if (Out1_SEND === 1'b1 && Out1_ACK === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_token", 32'(Out1_DATA), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("mon_data", 32'(Out1_DATA), 32'(e.d));
                        chk("mon_count", 32'(Out1_COUNT), 32'd1);
                        chk("mon_eof", 32'(Out1_EOF), 32'(e.eof));
                    end
                end else begin
                    chk("eof_idle", 32'(Out1_EOF), 32'd0);
                end
                prev_hold = (Out1_SEND === 1'b1) && (Out1_ACK !== 1'b1);
                prev_data = Out1_DATA;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] t1_vals [3];
    logic       t1_send [6];
    logic [7:0] t1_data [6];

    initial begin
        RESET    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h0;
        Out1_ACK = 1'b0;
        Out1_RDY = 1'b0;
        tick();
        tick();
        chk("rst_send", 32'(Out1_SEND), 32'd0);
        chk("rst_data", 32'(Out1_DATA), 32'd0);
        chk("rst_count", 32'(Out1_COUNT), 32'd0);
        chk("rst_full", 32'(wr_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_eof", 32'(Out1_EOF), 32'd0);
        RESET = 1'b1;
        tick();

        // Three writes, consumer always ready and acknowledging.
        t1_vals[0] = 8'h11; t1_vals[1] = 8'h22; t1_vals[2] = 8'h33;
        t1_send = '{0, 1, 1, 1, 0, 0};
        t1_data = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h33, 8'h33};
        Out1_RDY = 1'b1;
        Out1_ACK = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                wr_en   = 1'b1;
                wr_data = t1_vals[k];
                sb_push(t1_vals[k]);
            end else begin
                wr_en = 1'b0;
            end
            tick();
            chk($sformatf("t1_send_%0d", k), 32'(Out1_SEND), 32'(t1_send[k]));
            chk($sformatf("t1_count_%0d", k), 32'(Out1_COUNT), 32'(t1_send[k]));
            if (k >= 1 && k <= 3)
                chk($sformatf("t1_data_%0d", k), 32'(Out1_DATA), 32'(t1_data[k]));
        end

        // Single token held back by RDY; stray ACK while idle.
        Out1_RDY = 1'b0;
        Out1_ACK = 1'b0;
        wr_en    = 1'b1;
        wr_data  = 8'hA5;
        sb_push(8'hA5);
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            Out1_ACK = (k == 2);
            tick();
            chk("t2_idle_send", 32'(Out1_SEND), 32'd0);
        end
        Out1_ACK = 1'b0;
        Out1_RDY = 1'b1;
        tick();
        chk("t2_send_rise", 32'(Out1_SEND), 32'd1);
        chk("t2_data", 32'(Out1_DATA), 32'hA5);
        for (int k = 0; k < 3; k++) begin
            Out1_RDY = k[0];
            tick();
            chk("t2_hold_send", 32'(Out1_SEND), 32'd1);
            chk("t2_hold_data", 32'(Out1_DATA), 32'hA5);
        end
        Out1_ACK = 1'b1;
        tick();
        chk("t2_after_ack", 32'(Out1_SEND), 32'd0);
        Out1_ACK = 1'b0;
        Out1_RDY = 1'b0;

        // Fill, write-with-pop while full, then a dropped write.
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h40 + 8'(i);
            sb_push(wr_data);
            tick();
            if (i == 14) chk("t3_not_full_15", 32'(wr_full), 32'd0);
        end
        wr_en = 1'b0;
        chk("t3_full", 32'(wr_full), 32'd1);
        chk("t3_ovf_clear", 32'(overflow), 32'd0);
        wr_en    = 1'b1;
        wr_data  = 8'h77;
        Out1_RDY = 1'b1;
        sb_push(8'h77);
        tick();
        wr_en    = 1'b0;
        Out1_RDY = 1'b0;
        chk("t3_pop_full", 32'(wr_full), 32'd1);
        chk("t3_pop_ovf", 32'(overflow), 32'd0);
        chk("t3_pop_send", 32'(Out1_SEND), 32'd1);
        chk("t3_pop_data", 32'(Out1_DATA), 32'h40);
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        chk("t3_drop_ovf", 32'(overflow), 32'd1);
        chk("t3_drop_full", 32'(wr_full), 32'd1);
        Out1_ACK = 1'b1;
        Out1_RDY = 1'b1;
        wait_drain(200);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        Out1_ACK = 1'b0;
        Out1_RDY = 1'b0;
        tick();

        // Reset while offering with four entries queued.
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h81 + 8'(i);
            sb_push(wr_data);
            tick();
        end
        wr_en    = 1'b0;
        Out1_RDY = 1'b1;
        tick();
        Out1_RDY = 1'b0;
        chk("t4_offer_send", 32'(Out1_SEND), 32'd1);
        chk("t4_offer_data", 32'(Out1_DATA), 32'h81);
        RESET   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        RESET = 1'b1;
        wr_en = 1'b0;
        sb.delete();
        ord = 0;
        chk("t4_rst_send", 32'(Out1_SEND), 32'd0);
        chk("t4_rst_data", 32'(Out1_DATA), 32'd0);
        chk("t4_rst_full", 32'(wr_full), 32'd0);
        chk("t4_rst_ovf", 32'(overflow), 32'd0);
        chk("t4_rst_count", 32'(Out1_COUNT), 32'd0);
        Out1_RDY = 1'b1;
        Out1_ACK = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t4_no_token", 32'(Out1_SEND), 32'd0);
        end

        // Nine streamed tokens; EOF on the 4th and 8th when enabled.
        eof_seen = 0;
        for (int i = 1; i <= 9; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            sb_push(wr_data);
            tick();
        end
        wr_en = 1'b0;
        wait_drain(100);
        chk("t5_eof_count", 32'(eof_seen), EOF_ON ? 32'd2 : 32'd0);
        Out1_ACK = 1'b0;
        Out1_RDY = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
